// File: rtl/sha256_msg_schedule.sv
// ============================================================================
// Module   : sha256_msg_schedule
// Purpose  : SHA-256 message-schedule expander; loads 16 words, streams W[0..63].
//            Optional macro SHA256_SCHED_SIGMA_REG_EN splits each expansion into two cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic [5:0]  o_out_index,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2
    } state_t;

    localparam logic [6:0] c_LAST_LOAD = 7'd15;
    localparam logic [5:0] c_LAST_WORD = 6'd63;

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_t;
    logic [31:0] r_buf [16];
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [5:0]  r_out_index;
    logic        r_done;

    logic        w_free;
    logic        w_load_fire;
    logic        w_gen;
    logic        w_out_load;
    logic        w_last_hs;
    logic [31:0] w_new;
    logic [31:0] w_out_word;
    logic [3:0]  w_i0;
    logic [3:0]  w_i1;
    logic [3:0]  w_i7;
    logic [3:0]  w_i2;

    // Window slots for t-16, t-15, t-7, t-2 (mod 16)
    assign w_i0 = r_t[3:0];
    assign w_i1 = r_t[3:0] + 4'd1;
    assign w_i7 = r_t[3:0] + 4'd9;
    assign w_i2 = r_t[3:0] + 4'd14;

    assign w_free      = !r_out_valid || i_out_ready;
    assign o_in_ready  = (r_state == S_LOAD) && w_free;
    assign w_load_fire = i_in_valid && o_in_ready;
    assign w_last_hs   = (r_state == S_EXPAND) && r_out_valid && i_out_ready
                         && (r_out_index == c_LAST_WORD);

`ifdef SHA256_SCHED_SIGMA_REG_EN
    logic        r_phase;
    logic [31:0] r_s1;
    logic [31:0] r_s0p;
    logic        w_gen_a;

    // Phase A only starts once the output register drains, so phase B always finds it free
    assign w_gen_a = (r_state == S_EXPAND) && !r_t[6] && !r_phase && w_free;
    assign w_gen   = (r_state == S_EXPAND) && r_phase;
    assign w_new   = r_s1 + r_buf[w_i7] + r_s0p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_s1    <= 32'd0;
            r_s0p   <= 32'd0;
        end else if (w_gen_a) begin
            r_phase <= 1'b1;
            r_s1    <= f_sigma1(r_buf[w_i2]);
            r_s0p   <= f_sigma0(r_buf[w_i1]) + r_buf[w_i0];
        end else if (w_gen) begin
            r_phase <= 1'b0;
        end
    end
`else
    assign w_gen = (r_state == S_EXPAND) && !r_t[6] && w_free;
    assign w_new = f_sigma1(r_buf[w_i2]) + r_buf[w_i7]
                 + f_sigma0(r_buf[w_i1]) + r_buf[w_i0];
`endif

    assign w_out_load = w_load_fire || w_gen;
    assign w_out_word = w_load_fire ? i_in_data : w_new;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_LOAD;
            S_LOAD:   if (w_load_fire && (r_t == c_LAST_LOAD)) w_state_nxt = S_EXPAND;
            S_EXPAND: if (w_last_hs) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t         <= 7'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_index <= 6'd0;
            r_done      <= 1'b0;
            for (int i = 0; i < 16; i++) r_buf[i] <= 32'd0;
        end else begin
            r_done <= w_last_hs;
            if ((r_state == S_IDLE) && i_start) r_t <= 7'd0;
            // New word overwrites slot t (= W[t-16]) in the same edge it is consumed
            if (w_out_load) begin
                r_buf[w_i0] <= w_out_word;
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_word;
                r_out_index <= r_t[5:0];
                r_t         <= r_t + 7'd1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_index = r_out_index;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Purpose  : Randomized self-checking bench for sha256_msg_schedule against a
//            plain-arithmetic schedule model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_msg_schedule;

`ifdef SHA256_SCHED_SIGMA_REG_EN
    localparam int c_CYC_W63 = 113;
`else
    localparam int c_CYC_W63 = 65;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        i_out_ready = 1'b0;
    logic [31:0] i_in_data = 32'd0;
    logic        o_in_ready;
    logic        o_out_valid;
    logic [31:0] o_out_data;
    logic [5:0]  o_out_index;
    logic        o_busy;
    logic        o_done;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] m_blk [16];
    logic [31:0] m_exp [64];
    logic [31:0] got   [64];

    sha256_msg_schedule u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_data  (i_in_data),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_out_data (o_out_data),
        .o_out_index(o_out_index),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 recurrence over a full 64-entry array
    function automatic void build_expected();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) m_exp[t] = m_blk[t];
            else m_exp[t] = (rotr(m_exp[t-2], 17) ^ rotr(m_exp[t-2], 19) ^ (m_exp[t-2] >> 10))
                          + m_exp[t-7]
                          + (rotr(m_exp[t-15], 7) ^ rotr(m_exp[t-15], 18) ^ (m_exp[t-15] >> 3))
                          + m_exp[t-16];
        end
    endfunction

    function automatic void set_abc();
        for (int i = 0; i < 16; i++) m_blk[i] = 32'd0;
        m_blk[0]  = 32'h61626380;
        m_blk[15] = 32'h00000018;
    endfunction

    task automatic run_block(input int rdy_pct, input int vld_pct, input bit poke,
                             input int abort_at, output int cyc63);
        int          lp;
        int          oc;
        int          cyc;
        bit          last;
        bit          held_v;
        bit          finished;
        logic [31:0] held_d;
        logic [5:0]  held_i;
        build_expected();
        lp = 0; oc = 0; last = 0; held_v = 0; finished = 0; cyc63 = -1;
        held_d = 32'd0; held_i = 6'd0;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 1;
        check("in_ready_cycle1", {31'b0, o_in_ready}, 32'd1);
        while (!finished && cyc < 3000) begin
            i_out_ready = ($urandom_range(0, 99) < rdy_pct);
            i_in_valid  = (lp < 16) && ($urandom_range(0, 99) < vld_pct);
            i_in_data   = i_in_valid ? m_blk[lp] : $urandom;
            i_start     = 1'b0;
            if (poke && lp == 16 && oc >= 20 && oc < 60) begin
                i_start    = 1'b1;
                i_in_valid = 1'b1;
            end
            #1;
            if (held_v) begin
                check("stall_data", o_out_data, held_d);
                check("stall_index", {26'b0, o_out_index}, {26'b0, held_i});
            end
            if (poke && lp == 16) check("in_ready_expand", {31'b0, o_in_ready}, 32'd0);
            if (cyc63 < 0 && o_out_valid && o_out_index == 6'd63) cyc63 = cyc;
            if (abort_at >= 0 && o_out_valid && int'(o_out_index) == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("abort_valid", {31'b0, o_out_valid}, 32'd0);
                check("abort_data", o_out_data, 32'd0);
                check("abort_index", {26'b0, o_out_index}, 32'd0);
                check("abort_busy", {31'b0, o_busy}, 32'd0);
                check("abort_done", {31'b0, o_done}, 32'd0);
                check("abort_in_ready", {31'b0, o_in_ready}, 32'd0);
                finished = 1;
            end else begin
                check("no_early_done", {31'b0, o_done}, 32'd0);
                if (o_out_valid && i_out_ready) begin
                    check("index", {26'b0, o_out_index}, oc);
                    check("data", o_out_data, m_exp[oc]);
                    got[oc] = o_out_data;
                    if (oc == 63) last = 1;
                    oc++;
                end
                if (o_in_ready && i_in_valid && lp < 16) lp++;
                held_v = o_out_valid && !i_out_ready;
                held_d = o_out_data;
                held_i = o_out_index;
                @(posedge clk); #1;
                cyc++;
                if (last) begin
                    check("done_pulse", {31'b0, o_done}, 32'd1);
                    check("busy_at_done", {31'b0, o_busy}, 32'd0);
                    check("valid_at_done", {31'b0, o_out_valid}, 32'd0);
                    i_out_ready = 1'b1;
                    i_in_valid  = 1'b0;
                    @(posedge clk); #1;
                    check("done_single", {31'b0, o_done}, 32'd0);
                    finished = 1;
                end
            end
        end
        check("block_finished", {31'b0, finished}, 32'd1);
        i_start = 1'b0;
        i_in_valid = 1'b0;
    endtask

    task automatic check_abc_consts(input string tag);
        check({tag, "_w0"},  got[0],  32'h61626380);
        check({tag, "_w15"}, got[15], 32'h00000018);
        check({tag, "_w16"}, got[16], 32'h61626380);
        check({tag, "_w17"}, got[17], 32'h000F0000);
        check({tag, "_w18"}, got[18], 32'h7DA86405);
        check({tag, "_w19"}, got[19], 32'h600003C6);
    endtask

    initial begin
        int c63;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, o_in_ready}, 32'd0);
        check("rst_valid", {31'b0, o_out_valid}, 32'd0);
        check("rst_data", o_out_data, 32'd0);
        check("rst_index", {26'b0, o_out_index}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        set_abc();
        run_block(100, 100, 0, -1, c63);
        check_abc_consts("abc");
        check("abc_w63_cycle", c63, c_CYC_W63);

        for (int i = 0; i < 16; i++) m_blk[i] = 32'd0;
        run_block(100, 100, 0, -1, c63);
        check("zero_w40", got[40], 32'd0);

        set_abc();
        run_block(50, 100, 0, -1, c63);
        check_abc_consts("abc_bp");

        run_block(100, 100, 1, -1, c63);
        check_abc_consts("abc_poke");

        run_block(100, 100, 0, 30, c63);
        run_block(100, 100, 0, -1, c63);
        check_abc_consts("abc_after_rst");

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) m_blk[i] = $urandom;
            run_block($urandom_range(30, 100), $urandom_range(30, 100), 0, -1, c63);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

- Sequences the SHA-256 message-schedule expansion around the small-sigma functions (σ0: rotr7^rotr18^shr3, σ1: rotr17^rotr19^shr10).
- Accepts one 512-bit block as 16 streamed 32-bit words and emits the full schedule W[0..63], one word per handshake, to the compression round engine.
- Holds a 16-word circular window, so each W[t] for t≥16 is computed on the fly from buf[t-2], buf[t-7], buf[t-15] and buf[t-16].

## Interface

Parameters:
- none (schedule length fixed at 64 words, load length fixed at 16 words)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new block; honoured only in IDLE
- in_valid  in  1  in_data holds a message word
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  32  message word, big-endian word order W[0] first
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  consumer accepts output this cycle
- out_data  out  32  schedule word W[out_index]
- out_index  out  6  t of the presented word, 0..63
- busy  out  1  high in LOAD or EXPAND
- done  out  1  one-cycle pulse after W[63] is accepted

## Operation

- States: IDLE, LOAD, EXPAND.
- IDLE → LOAD on start. t counter cleared to 0.
- LOAD:
  - in_ready = !out_valid || out_ready.
  - On in_valid && in_ready, in_data is written to buf[t[3:0]] and loaded into the output register with out_index=t, then t increments.
  - After t=15 is accepted → EXPAND.
- EXPAND:
  - When the output register is free (!out_valid || out_ready), compute W[t] = σ1(buf[t-2]) + buf[t-7] + σ0(buf[t-15]) + buf[t-16].
  - All indices are mod 16; additions are mod 2^32 with carries discarded.
  - The result is written to buf[t[3:0]] (overwriting W[t-16] in the same edge it is consumed) and into the output register, then t increments.
  - After t=63 is loaded, no further words are generated.
- Completion: the handshake of out_index=63 → done=1 for the next cycle and state → IDLE.
- Output register:
  - out_valid stays high with out_data/out_index stable until out_ready.
  - One word per cycle is possible with no bubbles.
- Ignored inputs: start outside IDLE; in_valid outside LOAD (in_ready=0).
- busy=1 in LOAD and EXPAND. busy=0 in IDLE, including the done cycle.

## Timing

- Reset values: state IDLE, t=0, in_ready=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0. buf contents don't-care; cleared to 0 for simulation determinism.
- Reset mid-LOAD or mid-EXPAND aborts immediately to the reset values. No done is produced.
- start sampled at edge 0 → LOAD from cycle 1. in_ready is 1 in cycle 1.
- LOAD latency: word accepted at edge k → visible on out_data from cycle k+1.
- EXPAND without backpressure (out_ready=1): W[16] is presented the cycle after W[15]; sustained 1 word/cycle.
- Full block with in_valid=out_ready=1 continuously: W[63] presented at cycle 65 after start, done=1 at cycle 66.
- Backpressure: with out_ready=0, neither in_ready nor computation advances; t, buf and the output register are frozen.
- Simultaneous out_ready handshake and new load in the same cycle is required (no bubble).

## Configuration

- SHA256_SCHED_SIGMA_REG_EN
  - Defined: EXPAND splits each word into two cycles. Cycle A registers σ1(buf[t-2]) and σ0(buf[t-15])+buf[t-16]. Cycle B adds buf[t-7] and loads the output. Throughput in EXPAND is 1 word per 2 cycles; LOAD is unchanged; done arrives 48 cycles later than without the macro.
  - Undefined: single-cycle combinational expansion as described above.
  - Output values are identical in both builds.

## Test plan

- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 → W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; W0..W15 echoed unchanged; done one cycle after index 63.
- All-zero block → all 64 out_data=0x00000000, out_index 0..63 in order, exactly one done pulse.
- "abc" block with out_ready pseudo-random 50% → identical word sequence to the first test; out_data stable while out_valid && !out_ready; no index skipped or repeated.
- start pulsed during EXPAND and in_valid held high in EXPAND → no effect, sequence unchanged, in_ready=0.
- rst asserted at out_index=30 → next cycle all outputs at reset values; new start with the "abc" block reproduces the first-test results.
- Build with SHA256_SCHED_SIGMA_REG_EN, "abc" block, out_ready=1 → same W values; EXPAND presents one new word every 2 cycles.
